mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised, registered N-way source selector for the datapath; the next generation of the fixed 5-input combinational mux.
- Selects one of NUM_SRC packed WIDTH-bit sources per transaction.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the consumer never drops or duplicates a word.
- Flags out-of-range selects instead of producing undefined data.

Parameters:
- WIDTH, 32, bit width of each source and of the output.
- NUM_SRC, 5, number of sources; legal range 2..16.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_SRC.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- src  in  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  source index for this transaction.
- in_valid  in  1  sel/src are valid this cycle.
- in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready.
- out_data  out  WIDTH  selected word.
- out_err  out  1  the word in out_data came from an out-of-range sel.
- out_valid  out  1  out_data/out_err are valid.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.

Behaviour:
- Reset (async, asserted): out_data=0, out_err=0, out_valid=0, skid buffer empty, in_ready=1. All effects are immediate, not clock-gated.
- Reset mid-operation: all buffered words are discarded; no partial transfer completes.
- Capture on input transfer:
  - sel < NUM_SRC: word = src[sel], err = 0.
  - sel >= NUM_SRC: word = 0, err = 1.
- Storage: main register (drives the outputs) plus one skid register.
- State machine (register only; no combinational path from in to out):
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> load main, go FULL1.
  - FULL1: in_ready=1, out_valid=1.
    - Input transfer and output transfer together -> reload main, stay FULL1.
    - Input transfer only -> load skid, go FULL2.
    - Output transfer only -> go EMPTY.
  - FULL2: in_ready=0, out_valid=1. Output transfer -> move skid into main, go FULL1. in_valid is ignored.
- in_ready is a registered output, with no combinational dependency on out_ready.
- Latency: 1 cycle from input transfer to out_valid when EMPTY.
- Throughput: 1 word/cycle while out_ready=1.
- out_data and out_err hold stable while out_valid=1 and out_ready=0.
- src and sel are sampled only at an input transfer; changes at other times have no effect.
- Ordering is strictly FIFO; at most 2 words are in flight.

Optional Feature:
- Macro MUX_ERR_CNT_EN.
- Defined: adds output err_cnt (8 bits).
  - Increments on each input transfer with sel >= NUM_SRC.
  - Saturates at 255; reset value 0.
  - Adds input err_clr (1 bit): synchronous clear to 0, and err_clr takes priority over increment.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
1. Sources 50, 10, 128, 998, 225; out_ready=1; send sel=1,0,3,2,4 back-to-back -> out_data 10, 50, 998, 128, 225, one per cycle, each 1 cycle after its input; out_err=0 throughout.
2. sel=5, then sel=7 -> out_data=0, out_err=1 for both. With MUX_ERR_CNT_EN, err_cnt=2; pulse err_clr -> err_cnt=0.
3. out_ready=0; send sel=2 then sel=3 -> in_ready=0 after the second accept, out_data=128 held; raise out_ready -> 128 then 998; in_ready=1 one cycle after the first drain.
4. out_ready toggling every cycle for 20 transfers over a random sel sequence -> output sequence matches the input order exactly, with no loss and no duplication.
5. Assert rst while in FULL2 -> out_valid=0 and in_ready=1 immediately. Next transfer with sel=4 -> 225.
6. WIDTH=8, NUM_SRC=16, SEL_W=4 with src[i]=i+100; sweep sel 0..15 -> out_data 100..115, out_err=0.

Source files
------------

// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: packed sources and select in, selected word out.
// The master modport is the producer/consumer side and the slave modport is the selector.
interface mux_n_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
);
  logic [NUM_SRC*WIDTH-1:0] src;
  logic [SEL_W-1:0]         sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_err;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output src, sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  src, sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/mux_n_pipe.sv
// Registered NUM_SRC-way selector: 1-cycle latency, 2-entry skid so back-pressure never drops or repeats a word.
// Defining MUX_ERR_CNT_EN adds err_cnt/err_clr, a saturating count of out-of-range selects.
module mux_n_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MUX_ERR_CNT_EN
  input  logic        err_clr,
  output logic [7:0]  err_cnt,
`endif
  mux_n_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL1 = 2'd1,
    S_FULL2 = 2'd2
  } state_t;

  localparam logic [SEL_W:0] LP_NUM_SRC = (SEL_W+1)'(NUM_SRC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [WIDTH-1:0] w_main_data_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic [WIDTH-1:0] w_cap_data;
  logic             r_main_err;
  logic             r_skid_err;
  logic             w_main_err_nxt;
  logic             w_skid_err_nxt;
  logic             w_cap_err;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  // Out-of-range selects match no source, so the captured word falls through to zero.
  always_comb begin
    w_cap_data = '0;
    w_cap_err  = ({1'b0, bus.sel} >= LP_NUM_SRC);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        w_cap_data = bus.src[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_err_nxt  = r_main_err;
    w_skid_data_nxt = r_skid_data;
    w_skid_err_nxt  = r_skid_err;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_main_data_nxt = w_cap_data;
          w_main_err_nxt  = w_cap_err;
          w_state_nxt     = S_FULL1;
        end
      end
      S_FULL1: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_data_nxt = w_cap_data;
          w_main_err_nxt  = w_cap_err;
        end else if (w_in_xfer) begin
          w_skid_data_nxt = w_cap_data;
          w_skid_err_nxt  = w_cap_err;
          w_state_nxt     = S_FULL2;
        end else if (w_out_xfer) begin
          w_state_nxt     = S_EMPTY;
        end
      end
      S_FULL2: begin
        // in_ready is low here, so the input side cannot transfer.
        if (w_out_xfer) begin
          w_main_data_nxt = r_skid_data;
          w_main_err_nxt  = r_skid_err;
          w_state_nxt     = S_FULL1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Handshake flags are decoded from the next state so both stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_err  <= w_main_err_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_err  <= w_skid_err_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL2);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_err   = r_main_err;

`ifdef MUX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= 8'd0;
    end else if (w_in_xfer && w_cap_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: default 5x32 instance plus a 16x8 instance.
module tb_mux_n_pipe;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   lat_chk = 1'b0;
  bit   tog     = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] src0 [5];

  mux_n_pipe_if #(.WIDTH(32), .NUM_SRC(5),  .SEL_W(3)) b0 ();
  mux_n_pipe_if #(.WIDTH(8),  .NUM_SRC(16), .SEL_W(4)) b1 ();

`ifdef MUX_ERR_CNT_EN
  logic       err_clr0 = 1'b0;
  logic       err_clr1 = 1'b0;
  logic [7:0] err_cnt0;
  logic [7:0] err_cnt1;
`endif

  mux_n_pipe #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
`ifdef MUX_ERR_CNT_EN
    .err_clr (err_clr0),
    .err_cnt (err_cnt0),
`endif
    .bus     (b0)
  );

  mux_n_pipe #(.WIDTH(8), .NUM_SRC(16), .SEL_W(4)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
`ifdef MUX_ERR_CNT_EN
    .err_clr (err_clr1),
    .err_cnt (err_cnt1),
`endif
    .bus     (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitors sample on the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!rst) begin
      if (b0.out_valid && b0.out_ready) begin
        chk("q0_has_entry", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("data0", 64'(b0.out_data), 64'(e.d));
          chk("err0", 64'(b0.out_err), 64'(e.e));
          if (lat_chk) chk("lat0", 64'(cyc - e.c), 64'd1);
        end
      end
      if (b0.in_valid && b0.in_ready) begin
        s   = int'(b0.sel);
        e.d = (s < 5) ? src0[s] : 32'd0;
        e.e = (s >= 5);
        e.c = cyc;
        q0.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!rst) begin
      if (b1.out_valid && b1.out_ready) begin
        chk("q1_has_entry", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("data1", 64'(b1.out_data), 64'(e.d));
          chk("err1", 64'(b1.out_err), 64'(e.e));
        end
      end
      if (b1.in_valid && b1.in_ready) begin
        s   = int'(b1.sel);
        e.d = 32'(100 + s);
        e.e = 1'b0;
        e.c = cyc;
        q1.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (tog) b0.out_ready = ~b0.out_ready;
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send0(input int s);
    int n = 0;
    b0.sel      = s[2:0];
    b0.in_valid = 1'b1;
    while (!b0.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("send0_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b0.sel      = 3'($urandom);
  endtask

  task automatic send1(input int s);
    int n = 0;
    b1.sel      = s[3:0];
    b1.in_valid = 1'b1;
    while (!b1.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("send1_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    b1.sel      = 4'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(n), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    src0 = '{32'd50, 32'd10, 32'd128, 32'd998, 32'd225};
    for (int i = 0; i < 5; i++) b0.src[i*32 +: 32] = src0[i];
    for (int i = 0; i < 16; i++) b1.src[i*8 +: 8] = 8'(100 + i);
    b0.sel = '0; b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    b1.sel = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;

    // Reset state, checked while reset is still asserted
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_in_ready",  64'(b0.in_ready),  64'd1);
    chk("rst_out_data",  64'(b0.out_data),  64'd0);
    chk("rst_out_err",   64'(b0.out_err),   64'd0);
    chk("rst_in_ready1", 64'(b1.in_ready),  64'd1);
`ifdef MUX_ERR_CNT_EN
    chk("rst_err_cnt",   64'(err_cnt0),     64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: back-to-back in-range selects, one-cycle latency
    lat_chk = 1'b1;
    send0(1); send0(0); send0(3); send0(2); send0(4);
    wait_drain();
    lat_chk = 1'b0;

    // 2: out-of-range selects
    send0(5); send0(7);
    wait_drain();
`ifdef MUX_ERR_CNT_EN
    chk("err_cnt_two", 64'(err_cnt0), 64'd2);
    err_clr0 = 1'b1;
    @(posedge clk);
    #1 err_clr0 = 1'b0;
    chk("err_cnt_clr", 64'(err_cnt0), 64'd0);
`endif

    // 3: fill both slots under back-pressure, then drain
    b0.out_ready = 1'b0;
    send0(2);
    chk("fill_in_ready1", 64'(b0.in_ready), 64'd1);
    send0(3);
    chk("full2_in_ready", 64'(b0.in_ready),  64'd0);
    chk("full2_valid",    64'(b0.out_valid), 64'd1);
    chk("full2_data",     64'(b0.out_data),  64'd128);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_data",      64'(b0.out_data),  64'd128);
    chk("hold_in_ready",  64'(b0.in_ready),  64'd0);
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_in_ready", 64'(b0.in_ready),  64'd1);
    chk("drain_data",     64'(b0.out_data),  64'd998);
    wait_drain();

    // 4: consumer toggles ready every cycle over random selects
    tog = 1'b1;
    for (int i = 0; i < 20; i++) send0(int'($urandom_range(0, 7)));
    tog = 1'b0;
    b0.out_ready = 1'b1;
    wait_drain();

    // 5: reset while both slots are occupied
    b0.out_ready = 1'b0;
    send0(0); send0(1);
    chk("pre_rst_in_ready", 64'(b0.in_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst5_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst5_in_ready",  64'(b0.in_ready),  64'd1);
    chk("rst5_out_data",  64'(b0.out_data),  64'd0);
    q0.delete();
`ifdef MUX_ERR_CNT_EN
    chk("rst5_err_cnt",   64'(err_cnt0),     64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    b0.out_ready = 1'b1;
    send0(4);
    wait_drain();

    // 6: 16-way, 8-bit instance sweep
    for (int s = 0; s < 16; s++) send1(s);
    wait_drain();

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
